// File: rtl/quad_encoder_tx.sv
// Quadrature transmitter: turns left/right step requests into rotary-encoder A/B
// detent cycles, buffering pending steps in a saturating signed counter.
module quad_encoder_tx #(
  parameter int PHASE_CYCLES = 4,
  parameter int CNT_W        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic step_right,
  input  logic step_left,
  output logic rota,
  output logic rotb,
  output logic busy,
  output logic overflow
);

  localparam int TMR_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PHASE_CYCLES - 1);
  localparam logic signed [CNT_W-1:0] P_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] P_MIN = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic signed [CNT_W-1:0] P_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, PH4} state_t;

  state_t                  state, state_n;
  logic [TMR_W-1:0]        timer, timer_n;
  logic signed [CNT_W-1:0] pend, pend_n, pend_adj;
  logic                    dir_cw, dir_cw_n;
  logic                    start, phase_end;
  logic                    ovf_n, rota_n, rotb_n, busy_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      pend     <= '0;
      dir_cw   <= 1'b0;
      rota     <= 1'b0;
      rotb     <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      pend     <= pend_n;
      dir_cw   <= dir_cw_n;
      rota     <= rota_n;
      rotb     <= rotb_n;
      busy     <= busy_n;
      overflow <= ovf_n;
    end
  end

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    dir_cw_n  = dir_cw;
    start     = 1'b0;
    phase_end = (timer == TMR_LAST);

    unique case (state)
      IDLE: start = (pend != '0);
      PH1, PH2, PH3: begin
        if (phase_end) begin
          state_n = state_t'(state + 3'd1);
          timer_n = '0;
        end else begin
          timer_n = timer + TMR_W'(1);
        end
      end
      PH4: begin
        if (phase_end) begin
          start   = (pend != '0);
          state_n = IDLE;
          timer_n = '0;
        end else begin
          timer_n = timer + TMR_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase

    if (start) begin
      state_n  = PH1;
      timer_n  = '0;
      dir_cw_n = ~pend[CNT_W-1];
    end
  end

  // Consumption happens first so a request arriving on the same edge sees the freed slot.
  always_comb begin
    pend_adj = pend;
    if (start) pend_adj = pend[CNT_W-1] ? (pend + P_ONE) : (pend - P_ONE);
    pend_n = pend_adj;
    ovf_n  = 1'b0;
    if (step_right && !step_left) begin
      if (pend_adj == P_MAX) ovf_n  = 1'b1;
      else                   pend_n = pend_adj + P_ONE;
    end else if (step_left && !step_right) begin
      if (pend_adj == P_MIN) ovf_n  = 1'b1;
      else                   pend_n = pend_adj - P_ONE;
    end
  end

  // Outputs are registered from the next state so they line up with state entry.
  always_comb begin
    rota_n = 1'b0;
    rotb_n = 1'b0;
    unique case (state_n)
      PH1:     {rota_n, rotb_n} = dir_cw_n ? 2'b10 : 2'b01;
      PH2:     {rota_n, rotb_n} = 2'b11;
      PH3:     {rota_n, rotb_n} = dir_cw_n ? 2'b01 : 2'b10;
      default: {rota_n, rotb_n} = 2'b00;
    endcase
    busy_n = (state_n != IDLE) || (pend_n != '0);
  end

endmodule

// File: tb/tb_quad_encoder_tx.sv
// Directed bench for quad_encoder_tx with an inline Gray/rotor-decoder monitor.
module tb_quad_encoder_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic step_right = 1'b0;
  logic step_left  = 1'b0;
  logic rota, rotb, busy, overflow;

  int checks = 0;
  int errors = 0;
  int gray_err = 0;
  int ticks_r = 0;
  int ticks_l = 0;
  logic [1:0] prev_ab = 2'b00;

  quad_encoder_tx #(.PHASE_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .step_right(step_right), .step_left(step_left),
    .rota(rota), .rotb(rotb), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Loopback decoder: a detent ends at 00, entered from 01 (right) or 10 (left).
  always @(negedge clk) begin
    if (!rst) begin
      if ((prev_ab ^ {rota, rotb}) == 2'b11) gray_err++;
      if ({rota, rotb} == 2'b00 && prev_ab == 2'b01) ticks_r++;
      if ({rota, rotb} == 2'b00 && prev_ab == 2'b10) ticks_l++;
    end
    prev_ab = {rota, rotb};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Hand-derived pattern for a detent starting in cycle 2 (cw: 10,11,01,00; ccw: 01,11,10,00).
  function automatic int exp_ab(input int cyc, input bit cw);
    int ph;
    if (cyc < 2) return 0;
    ph = ((cyc - 2) / 4) % 4;
    case (ph)
      0: return cw ? 2 : 1;
      1: return 3;
      2: return cw ? 1 : 2;
      default: return 0;
    endcase
  endfunction

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 600) begin tick(); n++; end
    chk(tag, int'(busy), 0);
    repeat (3) tick();
  endtask

  initial begin
    int r0, l0;
    // reset state
    #2;
    chk("rst_ab", int'({rota, rotb}), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(overflow), 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // single right detent
    r0 = ticks_r;
    step_right = 1'b1; tick(); step_right = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      chk($sformatf("cw_ab_c%0d", c), int'({rota, rotb}), (c <= 17) ? exp_ab(c, 1'b1) : 0);
      chk($sformatf("cw_busy_c%0d", c), int'(busy), (c <= 17) ? 1 : 0);
      tick();
    end
    chk("cw_ticks", ticks_r - r0, 1);

    // single left detent
    l0 = ticks_l;
    step_left = 1'b1; tick(); step_left = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      chk($sformatf("ccw_ab_c%0d", c), int'({rota, rotb}), (c <= 17) ? exp_ab(c, 1'b0) : 0);
      chk($sformatf("ccw_busy_c%0d", c), int'(busy), (c <= 17) ? 1 : 0);
      tick();
    end
    chk("ccw_ticks", ticks_l - l0, 1);

    // simultaneous requests cancel
    step_right = 1'b1; step_left = 1'b1; tick(); step_right = 1'b0; step_left = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      chk("both_ab", int'({rota, rotb}), 0);
      chk("both_busy", int'(busy), 0);
      chk("both_ovf", int'(overflow), 0);
      tick();
    end

    // three right pulses back to back: 12 gapless phases
    r0 = ticks_r; l0 = ticks_l; gray_err = 0;
    step_right = 1'b1; tick(); tick(); tick(); step_right = 1'b0;
    for (int c = 3; c <= 50; c++) begin
      chk($sformatf("x3_ab_c%0d", c), int'({rota, rotb}), (c <= 49) ? exp_ab(c, 1'b1) : 0);
      chk($sformatf("x3_busy_c%0d", c), int'(busy), (c <= 49) ? 1 : 0);
      tick();
    end
    chk("x3_right", ticks_r - r0, 3);
    chk("x3_left", ticks_l - l0, 0);
    chk("x3_gray", gray_err, 0);
    repeat (2) tick();

    // nine right pulses: saturate at 7, 9th overflows, 8 detents total
    r0 = ticks_r; gray_err = 0;
    step_right = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c <= 8) chk($sformatf("sat_ovf_c%0d", c), int'(overflow), 0);
    end
    step_right = 1'b0;
    chk("sat_ovf_c9", int'(overflow), 1);
    tick();
    chk("sat_ovf_c10", int'(overflow), 0);
    wait_idle("sat_idle");
    chk("sat_right", ticks_r - r0, 8);
    chk("sat_gray", gray_err, 0);

    // reset during PH2 of a cw detent with 2 pending
    step_right = 1'b1; tick(); tick(); tick(); step_right = 1'b0;
    repeat (4) tick();
    chk("mid_ph2_ab", int'({rota, rotb}), 3);
    rst = 1'b1;
    #1;
    chk("mid_rst_ab", int'({rota, rotb}), 0);
    chk("mid_rst_busy", int'(busy), 0);
    tick(); tick();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      chk("post_rst_ab", int'({rota, rotb}), 0);
      chk("post_rst_busy", int'(busy), 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
